fetch_unit: RTL and testbench

Instruction fetch stage between `program_counter` and the decoder. It reads the current PC and issues one instruction-word read at a time on the memory bus. It pulses the PC increment when each word arrives and buffers fetched words with their addresses in a small prefetch FIFO for the decoder. A redirect (taken jump) flushes the FIFO and discards any in-flight read.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_unit.sv | 116 +++++++++++
 tb/tb_fetch_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the fetch FSM state encodings and the address/instruction widths.
package fetch_pkg;

    localparam int unsigned INSTR_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH  = 32;
    localparam int unsigned ENTRY_WIDTH = ADDR_WIDTH + INSTR_WIDTH;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_REQ   = 2'd1,
        FS_DRAIN = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} entries for the decoder.
// Ports:
//   clock, reset  - clock and asynchronous active-low reset
//   push, wdata   - write an entry at the tail
//   pop           - drop the head entry
//   flush         - empty the FIFO; overrides push and pop on the same edge
//   count         - number of valid entries (0..DEPTH)
//   head          - head entry, {pc, instr}
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [ENTRY_WIDTH-1:0] wdata,
    output logic [CNT_W-1:0]       count,
    output logic [ENTRY_WIDTH-1:0] head
);

    logic [ENTRY_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]       wr_ptr_q;
    logic [PTR_W-1:0]       rd_ptr_q;
    logic [CNT_W-1:0]       count_q;

    // Storage is zeroed on reset so an empty FIFO presents a zero head.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues one word read at a time from the current PC,
// pulses the PC increment when each word arrives and buffers {pc, instr} pairs
// in a prefetch FIFO for the decoder. A redirect flushes the FIFO and discards
// any in-flight read.
// Ports:
//   clock, reset         - clock and asynchronous active-low reset
//   pc, pc_inc           - current PC in, combinational increment strobe out
//   redirect             - taken jump this cycle
//   mem_req, mem_addr    - registered read request and word address
//   mem_ack, mem_rdata   - read completion and data
//   instr_valid/ready    - decoder handshake on the FIFO head
//   instr, instr_pc      - head word and the address it was fetched from
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc,
    output logic                   pc_inc,
    input  logic                   redirect,
    output logic                   mem_req,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    input  logic                   mem_ack,
    input  logic [INSTR_WIDTH-1:0] mem_rdata,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e          state_q, state_d;
    logic                  mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;

    logic                   push;
    logic                   pop;
    logic [CNT_W-1:0]       count;
    logic [ENTRY_WIDTH-1:0] head;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= FS_IDLE;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        push       = 1'b0;
        pc_inc     = 1'b0;
        unique case (state_q)
            FS_IDLE: begin
                // pc is not reloaded yet during a redirect, so wait a cycle.
                if (!redirect && (count < CNT_W'(DEPTH))) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = pc;
                    state_d    = FS_REQ;
                end
            end
            FS_REQ: begin
                if (mem_ack) begin
                    push      = !redirect;
                    pc_inc    = !redirect;
                    mem_req_d = 1'b0;
                    state_d   = FS_IDLE;
                end else if (redirect) begin
                    state_d = FS_DRAIN;
                end
            end
            FS_DRAIN: begin
                // Read belongs to the abandoned path; wait out the ack.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = FS_IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = FS_IDLE;
            end
        endcase
    end

    assign pop = instr_valid && instr_ready;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({mem_addr_q, mem_rdata}),
        .count (count),
        .head  (head)
    );

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = (count != '0);
    assign instr_pc    = head[ENTRY_WIDTH-1:INSTR_WIDTH];
    assign instr       = head[INSTR_WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit. Inputs are driven on the falling edge and
// outputs checked 1ns later; a small program_counter model supplies pc.
module tb_fetch_unit;
    import fetch_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        pc_rst = 1'b0;
    logic [31:0] pc;
    logic        pc_inc;
    logic        redirect = 1'b0;
    logic [31:0] target = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;

    int total = 0;
    int bad = 0;
    int inc_cnt = 0;

    always #5 clock = ~clock;

    fetch_unit #(
        .DEPTH (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pc          (pc),
        .pc_inc      (pc_inc),
        .redirect    (redirect),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc)
    );

    // program_counter model; its reset is separate so pc survives a fetch reset.
    always_ff @(posedge clock or negedge pc_rst) begin
        if (!pc_rst) pc <= '0;
        else if (redirect) pc <= target;
        else if (pc_inc) pc <= pc + 32'd4;
    end

    always @(posedge clock) if (pc_inc) inc_cnt <= inc_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    initial begin
        // 1. Reset with mem_ack toggling.
        for (int i = 0; i < 3; i++) begin
            step();
            mem_ack = ~mem_ack;
            #1;
            chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
            chk("rst_valid", {31'd0, instr_valid}, 32'd0);
            chk("rst_pc_inc", {31'd0, pc_inc}, 32'd0);
        end
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        step();
        mem_ack = 1'b0;
        reset = 1'b1;
        pc_rst = 1'b1;
        step(); #1;
        chk("rel_mem_req", {31'd0, mem_req}, 32'd1);
        chk("rel_mem_addr", mem_addr, 32'd0);

        // 2. Basic zero-wait fetch into a non-draining decoder.
        mem_ack = 1'b1; mem_rdata = 32'hdeadbeef; #1;
        chk("b1_pc_inc", {31'd0, pc_inc}, 32'd1);
        step(); mem_ack = 1'b0; #1;
        chk("b1_valid", {31'd0, instr_valid}, 32'd1);
        chk("b1_instr", instr, 32'hdeadbeef);
        chk("b1_instr_pc", instr_pc, 32'd0);
        chk("b1_mem_req", {31'd0, mem_req}, 32'd0);
        chk("b1_pc_inc_lo", {31'd0, pc_inc}, 32'd0);
        step(); #1;
        chk("b2_mem_req", {31'd0, mem_req}, 32'd1);
        chk("b2_mem_addr", mem_addr, 32'd4);
        mem_ack = 1'b1; mem_rdata = 32'h12345678; #1;
        chk("b2_pc_inc", {31'd0, pc_inc}, 32'd1);
        step(); mem_ack = 1'b0; #1;
        chk("b2_req_lo", {31'd0, mem_req}, 32'd0);
        chk("b2_head", instr, 32'hdeadbeef);
        step(); #1;
        chk("full_no_req", {31'd0, mem_req}, 32'd0);
        chk("full_pc", pc, 32'd8);
        instr_ready = 1'b1; #1;
        chk("pop0_instr", instr, 32'hdeadbeef);
        chk("pop0_pc", instr_pc, 32'd0);
        step(); #1;
        chk("pop1_instr", instr, 32'h12345678);
        chk("pop1_pc", instr_pc, 32'd4);
        chk("pop1_no_req", {31'd0, mem_req}, 32'd0);
        step(); instr_ready = 1'b0; #1;
        chk("drained_valid", {31'd0, instr_valid}, 32'd0);
        chk("resume_req", {31'd0, mem_req}, 32'd1);
        chk("resume_addr", mem_addr, 32'd8);
        chk("inc_cnt_2", inc_cnt, 32'd2);

        // 3. Three wait states before the ack.
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step();
            #1;
            chk("ws_addr", mem_addr, 32'd8);
            chk("ws_req", {31'd0, mem_req}, 32'd1);
            chk("ws_pc_inc", {31'd0, pc_inc}, 32'd0);
        end
        step(); mem_ack = 1'b1; mem_rdata = 32'hcafef00d; #1;
        chk("ws_ack_addr", mem_addr, 32'd8);
        chk("ws_ack_inc", {31'd0, pc_inc}, 32'd1);
        step(); mem_ack = 1'b0; #1;
        chk("ws_instr", instr, 32'hcafef00d);
        chk("ws_instr_pc", instr_pc, 32'd8);
        chk("inc_cnt_3", inc_cnt, 32'd3);

        // 4. Redirect while a read is outstanding.
        step(); #1;
        chk("r4_addr", mem_addr, 32'd12);
        redirect = 1'b1; target = 32'h100; #1;
        chk("r4_pc_inc", {31'd0, pc_inc}, 32'd0);
        step(); redirect = 1'b0; #1;
        chk("r4_flushed", {31'd0, instr_valid}, 32'd0);
        chk("r4_req_held", {31'd0, mem_req}, 32'd1);
        chk("r4_addr_held", mem_addr, 32'd12);
        chk("r4_state", {30'd0, dut.state_q}, {30'd0, FS_DRAIN});
        step(); mem_ack = 1'b1; mem_rdata = 32'hbadbad00; #1;
        chk("r4_late_inc", {31'd0, pc_inc}, 32'd0);
        step(); mem_ack = 1'b0; #1;
        chk("r4_no_push", {31'd0, instr_valid}, 32'd0);
        chk("r4_req_lo", {31'd0, mem_req}, 32'd0);
        chk("inc_cnt_r4", inc_cnt, 32'd3);
        step(); #1;
        chk("r4_new_req", {31'd0, mem_req}, 32'd1);
        chk("r4_new_addr", mem_addr, 32'h100);

        // 5. Redirect coincident with ack and pop.
        mem_ack = 1'b1; mem_rdata = 32'h11111111; #1;
        step(); mem_ack = 1'b0; #1;
        chk("r5_valid", {31'd0, instr_valid}, 32'd1);
        chk("r5_instr_pc", instr_pc, 32'h100);
        step(); #1;
        chk("r5_addr", mem_addr, 32'h104);
        redirect = 1'b1; target = 32'h200; mem_ack = 1'b1; mem_rdata = 32'h22222222;
        instr_ready = 1'b1; #1;
        chk("r5_pc_inc", {31'd0, pc_inc}, 32'd0);
        step(); redirect = 1'b0; mem_ack = 1'b0; instr_ready = 1'b0; #1;
        chk("r5_empty", {31'd0, instr_valid}, 32'd0);
        chk("r5_req_lo", {31'd0, mem_req}, 32'd0);
        chk("inc_cnt_r5", inc_cnt, 32'd4);
        step(); #1;
        chk("r5_new_req", {31'd0, mem_req}, 32'd1);
        chk("r5_new_addr", mem_addr, 32'h200);

        // 6. Asynchronous reset while in FS_REQ.
        #1 reset = 1'b0; #1;
        chk("ar_req_lo", {31'd0, mem_req}, 32'd0);
        chk("ar_valid", {31'd0, instr_valid}, 32'd0);
        step(); reset = 1'b1; #1;
        chk("ar_idle_req", {31'd0, mem_req}, 32'd0);
        step(); #1;
        chk("ar_restart_req", {31'd0, mem_req}, 32'd1);
        chk("ar_restart_addr", mem_addr, 32'h200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
